armleo_mem_1rw_bytemask: RTL and testbench



---
 rtl/armleo_mem_1rw_bytemask.sv | 76 +++++++
 tb/tb_armleo_mem_1rw_bytemask.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/armleo_mem_1rw_bytemask.sv
// -----------------------------------------------------------------------------
// armleo_mem_1rw_bytemask
//
// Single-port synchronous RAM with per-byte write enables. Read and write
// share one word address. Reads are registered with one cycle of latency, and
// readdata holds its last value until the next read. This lets an upstream
// bus stall a read beat without issuing the read again.
//
// When a read and a write target the same word in one cycle, the read returns
// the old contents (read-first). The write is applied in the same cycle.
//
// Parameters
//   ELEMENTS_W : word address width; depth is 2**ELEMENTS_W words
//   WIDTH      : data width in bits; must be a multiple of 8
//
// Ports
//   clk         : clock; all logic is on the rising edge
//   rst         : synchronous active-high reset; clears readdata only
//   address     : word address, shared by read and write
//   read        : read strobe
//   readdata    : registered read data; holds between reads
//   write       : write strobe
//   writeenable : byte enables; bit i gates writedata[8*i +: 8]
//   writedata   : write data
// -----------------------------------------------------------------------------
module armleo_mem_1rw_bytemask #(
  parameter int ELEMENTS_W = 10,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ELEMENTS_W-1:0] address,
  input  logic                  read,
  output logic [WIDTH-1:0]      readdata,
  input  logic                  write,
  input  logic [WIDTH/8-1:0]    writeenable,
  input  logic [WIDTH-1:0]      writedata
);

  localparam int DEPTH = 2 ** ELEMENTS_W;
  localparam int LANES = WIDTH / 8;

  // Reject geometries the byte-lane slicing cannot represent.
  if ((WIDTH % 8) != 0 || WIDTH < 8 || ELEMENTS_W < 1) begin : g_param_check
    $error("armleo_mem_1rw_bytemask: WIDTH must be a nonzero multiple of 8 and ELEMENTS_W >= 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write path. Reset suppresses the write, but reset does not
  // clear the contents.
  // NOTE: the storage array deliberately has no reset branch. Resetting
  // every word would prevent the array from mapping onto block RAM. Words
  // read as X in simulation until they are written.
  always_ff @(posedge clk) begin
    if (!rst && write) begin
      for (int i = 0; i < LANES; i++) begin
        if (writeenable[i]) begin
          mem[address][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  // Registered read port with hold.
  // NOTE: non-blocking assignments give read-first behaviour for free. This
  // block samples mem[address] before the write block's update lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= mem[address];
    end
  end

endmodule

// File: tb/tb_armleo_mem_1rw_bytemask.sv
// -----------------------------------------------------------------------------
// tb_armleo_mem_1rw_bytemask
//
// Self-checking bench for armleo_mem_1rw_bytemask (default 10-bit address,
// 32-bit data). A reference word array tracks the memory contents. Each read
// pushes the expected word onto a scoreboard queue when the read is driven.
// The entry is popped and compared once readdata is valid, one edge later.
// Cycles without a read check that readdata holds the last expected value.
// -----------------------------------------------------------------------------
module tb_armleo_mem_1rw_bytemask;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic          read;
  logic [DW-1:0] readdata;
  logic          write;
  logic [BW-1:0] writeenable;
  logic [DW-1:0] writedata;

  armleo_mem_1rw_bytemask #(
    .ELEMENTS_W (AW),
    .WIDTH      (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .read        (read),
    .readdata    (readdata),
    .write       (write),
    .writeenable (writeenable),
    .writedata   (writedata)
  );

  always #5 clk = ~clk;

  // Reference contents and scoreboard.
  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_rd;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: readdata=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, update the reference, and check readdata
  // 1 time unit after the edge.
  task automatic cycle(input string tag, input logic rs, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [BW-1:0] be,
                       input logic [DW-1:0] d);
    logic popped;
    rst         = rs;
    read        = r;
    write       = w;
    address     = a;
    writeenable = be;
    writedata   = d;
    if (rs) begin
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      // The read sees the contents before this cycle's write (read-first).
      if (r) exp_q.push_back(model[a]);
      if (w) begin
        for (int i = 0; i < BW; i++) begin
          if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    popped = 1'b0;
    if (exp_q.size() > 0) begin
      exp_rd = exp_q.pop_front();
      popped = 1'b1;
    end
    check(popped ? tag : {tag, "_hold"}, readdata, exp_rd);
  endtask

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; writeenable = '0; writedata = '0;
    exp_rd = '0;

    // 1. Reset with read=0 clears readdata, which stays 0 after reset.
    cycle("reset",  1'b1, 1'b0, 1'b0, '0, '0, '0);
    cycle("reset",  1'b1, 1'b0, 1'b0, '0, '0, '0);
    cycle("idle",   1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle("idle",   1'b0, 1'b0, 1'b0, '0, '0, '0);

    // 2. Full-word write, then read back.
    cycle("wr5",    1'b0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    cycle("rd5",    1'b0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);

    // 3. Byte-lane write.
    cycle("wr5_be", 1'b0, 1'b0, 1'b1, 10'd5, 4'b0101, 32'h11223344);
    cycle("rd5_be", 1'b0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    check("lanes_const", readdata, 32'hDE22BE44);

    // 4. Hold: no reads while the address moves and addr 5 is rewritten.
    cycle("rd5_h",  1'b0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    cycle("hold1",  1'b0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hFFFFFFFF);
    cycle("hold2",  1'b0, 1'b0, 1'b0, 10'd9, 4'h0, 32'h0);
    cycle("hold3",  1'b0, 1'b0, 1'b1, 10'd5, 4'h3, 32'h0000CAFE);
    check("hold_const", readdata, 32'hDE22BE44);
    cycle("rd5_new",1'b0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);

    // 5. Same-cycle read and write: old data now, new data next read.
    cycle("wr7",    1'b0, 1'b0, 1'b1, 10'd7, 4'hF, 32'hAAAAAAAA);
    cycle("rw7",    1'b0, 1'b1, 1'b1, 10'd7, 4'hF, 32'h55555555);
    check("rw7_old_const", readdata, 32'hAAAAAAAA);
    cycle("rd7",    1'b0, 1'b1, 1'b0, 10'd7, 4'h0, 32'h0);
    check("rd7_new_const", readdata, 32'h55555555);

    // 6. Address boundaries and the no-op write (enables all zero).
    cycle("wr_lo",  1'b0, 1'b0, 1'b1, 10'd0,    4'hF, 32'h01234567);
    cycle("wr_hi",  1'b0, 1'b0, 1'b1, 10'd1023, 4'hF, 32'h89ABCDEF);
    cycle("rd_lo",  1'b0, 1'b1, 1'b0, 10'd0,    4'h0, 32'h0);
    cycle("rd_hi",  1'b0, 1'b1, 1'b0, 10'd1023, 4'h0, 32'h0);
    cycle("wr_nop", 1'b0, 1'b0, 1'b1, 10'd0,    4'h0, 32'hFFFFFFFF);
    cycle("rd_nop", 1'b0, 1'b1, 1'b0, 10'd0,    4'h0, 32'h0);

    // Reset mid-sequence with write=1 and read=1: the write is dropped, the
    // read is ignored, and readdata clears.
    cycle("rst_wr", 1'b1, 1'b1, 1'b1, 10'd5, 4'hF, 32'hBADBAD00);
    cycle("post_rst",1'b0, 1'b0, 1'b0, 10'd5, 4'h0, 32'h0);
    cycle("rd5_kept",1'b0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);

    // Randomised traffic over a small, fully initialised address window.
    for (int a = 0; a < 8; a++) begin
      cycle("init", 1'b0, 1'b0, 1'b1, AW'(a), 4'hF, $urandom);
    end
    for (int n = 0; n < 60; n++) begin
      cycle("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)), BW'($urandom_range(0, 15)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
